// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the I/D-cache to main-memory arbiter.
// Holds the state and owner encodings plus the default timing parameters.
package mem_arbiter_pkg;

    localparam int MEM_LATENCY_DEF = 4;
    localparam int BURST_LEN_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        I_BURST = 2'b01,
        D_BURST = 2'b10
    } arbState_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    // One slot of the response delay line: was a read issued, and for whom.
    typedef struct packed {
        logic   rd;
        owner_e owner;
    } respTag_t;

endpackage

// File: rtl/mem_arbiter_resp_tracker.sv
// Delay line matching each returning memory word to the cache that issued the read.
// The head slot lines up with m_valid exactly MEM_LATENCY cycles after issue.
module resp_tracker
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acceptRd,
    input  owner_e            acceptOwner,
    input  logic              m_valid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid
);

    respTag_t tagPipe [MEM_LATENCY-1:0];
    respTag_t head;
    logic     headHit;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MEM_LATENCY; k++) tagPipe[k] <= '0;
        end else begin
            tagPipe[0] <= '{rd: acceptRd, owner: acceptOwner};
            for (int k = 1; k < MEM_LATENCY; k++) tagPipe[k] <= tagPipe[k-1];
        end
    end

    assign head = tagPipe[MEM_LATENCY-1];

    // Data arriving against an empty head slot is stale and is dropped.
    assign headHit = !rst && m_valid && head.rd;
    assign i_valid = headHit && (head.owner == OWNER_I);
    assign d_valid = headHit && (head.owner == OWNER_D);
    assign i_rdata = i_valid ? m_rdata : '0;
    assign d_rdata = d_valid ? m_rdata : '0;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache word requests onto one pipelined memory port,
// locking the port to one cache for a whole block fill and routing read data back.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int BURST_LEN   = BURST_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    input  logic              d_en,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              m_en,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_valid
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    arbState_e          state, stateNext;
    owner_e             lastGrant, lastGrantNext;
    logic [CNT_W-1:0]   beatCnt, beatNext;
    logic               grantI, grantD;
    logic               ownerRd, lastBeat;
    logic               acceptRd;
    owner_e             acceptOwner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beatCnt   <= '0;
            lastGrant <= OWNER_I;   // D wins the first tie
        end else begin
            state     <= stateNext;
            beatCnt   <= beatNext;
            lastGrant <= lastGrantNext;
        end
    end

    always_comb begin
        stateNext     = state;
        beatNext      = beatCnt;
        lastGrantNext = lastGrant;
        grantI        = 1'b0;
        grantD        = 1'b0;
        ownerRd       = (state == I_BURST) ? (i_en && !i_wr) : (d_en && !d_wr);
        lastBeat      = (beatCnt == CNT_W'(BURST_LEN - 1));

        case (state)
            IDLE: begin
                if (i_en && d_en) begin
                    if (lastGrant == OWNER_I) begin
                        grantD        = 1'b1;
                        lastGrantNext = OWNER_D;
                    end else begin
                        grantI        = 1'b1;
                        lastGrantNext = OWNER_I;
                    end
                end else begin
                    grantI = i_en;
                    grantD = d_en;
                end
                // A granted read opens a fill; a granted write is a one-cycle event.
                if (BURST_LEN > 1) begin
                    if (grantI && !i_wr) begin
                        stateNext = I_BURST;
                        beatNext  = CNT_W'(1);
                    end
                    if (grantD && !d_wr) begin
                        stateNext = D_BURST;
                        beatNext  = CNT_W'(1);
                    end
                end
            end
            I_BURST, D_BURST: begin
                if (ownerRd) begin
                    grantI = (state == I_BURST);
                    grantD = (state == D_BURST);
                    if (lastBeat) begin
                        stateNext = IDLE;
                        beatNext  = '0;
                    end else begin
                        beatNext  = beatCnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                beatNext  = '0;
            end
        endcase

        if (rst) begin
            grantI = 1'b0;
            grantD = 1'b0;
        end
    end

    assign i_ready = grantI;
    assign d_ready = grantD;

    always_comb begin
        m_en    = 1'b0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (grantD) begin
            m_en    = d_en;
            m_wr    = d_wr;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (grantI) begin
            m_en    = i_en;
            m_wr    = i_wr;
            m_addr  = i_addr;
            m_wdata = i_wdata;
        end
    end

    assign acceptRd    = m_en && !m_wr;
    assign acceptOwner = grantD ? OWNER_D : OWNER_I;

    resp_tracker #(
        .DATA_W      (DATA_W),
        .MEM_LATENCY (MEM_LATENCY)
    ) uRespTracker (
        .clk         (clk),
        .rst         (rst),
        .acceptRd    (acceptRd),
        .acceptOwner (acceptOwner),
        .m_valid     (m_valid),
        .m_rdata     (m_rdata),
        .i_rdata     (i_rdata),
        .i_valid     (i_valid),
        .d_rdata     (d_rdata),
        .d_valid     (d_valid)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a pipelined memory model and a response scoreboard.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int LAT    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_en = 1'b0, i_wr = 1'b0, d_en = 1'b0, d_wr = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
    logic [DATA_W-1:0] i_wdata = '0, d_wdata = '0;
    logic              i_ready, i_valid, d_ready, d_valid;
    logic [DATA_W-1:0] i_rdata, d_rdata;
    logic              m_en, m_wr, m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(LAT), .BURST_LEN(8)) dut (
        .clk(clk), .rst(rst),
        .i_en(i_en), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_ready(i_ready), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_en(d_en), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_valid(d_valid),
        .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_valid(m_valid)
    );

    // Pipelined memory: a read seen at a clock edge returns LAT cycles after issue.
    function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
        return a ^ 16'hA5C3;
    endfunction

    logic [LAT-1:0]    memVld = '0;
    logic [DATA_W-1:0] memData [LAT];
    logic              forceVld = 1'b0;

    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) begin
            memVld[k]  <= memVld[k-1];
            memData[k] <= memData[k-1];
        end
        memVld[0]  <= m_en && !m_wr;
        memData[0] <= memWord(m_addr);
    end

    assign m_valid = forceVld | memVld[LAT-1];
    assign m_rdata = forceVld ? 16'hDEAD : memData[LAT-1];

    int nAsserts = 0;
    int nFails   = 0;
    int nRsp     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected word and owner queued on each accepted read, popped on return.
    typedef struct packed {
        logic              owner;
        logic [DATA_W-1:0] data;
    } rsp_t;
    rsp_t sb[$];
    rsp_t rspExp;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (i_valid || d_valid) begin
                check("one_valid", 32'(i_valid & d_valid), 32'd0);
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    rspExp = sb.pop_front();
                    check("rsp_owner", 32'(d_valid), 32'(rspExp.owner));
                    check("rsp_data", 32'(d_valid ? d_rdata : i_rdata), 32'(rspExp.data));
                    nRsp++;
                end
            end
            if (!i_valid) check("i_rdata_zero", 32'(i_rdata), 32'd0);
            if (!d_valid) check("d_rdata_zero", 32'(d_rdata), 32'd0);
            if (i_ready && !i_wr) sb.push_back({1'b0, memWord(i_addr)});
            if (d_ready && !d_wr) sb.push_back({1'b1, memWord(d_addr)});
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_en = 1'b0; d_en = 1'b0; i_wr = 1'b0; d_wr = 1'b0;
        repeat (n) nextCycle();
    endtask

    task automatic chkQuiet(input string tag);
        check({tag, "_i_ready"}, 32'(i_ready), 32'd0);
        check({tag, "_d_ready"}, 32'(d_ready), 32'd0);
        check({tag, "_i_valid"}, 32'(i_valid), 32'd0);
        check({tag, "_d_valid"}, 32'(d_valid), 32'd0);
        check({tag, "_i_rdata"}, 32'(i_rdata), 32'd0);
        check({tag, "_d_rdata"}, 32'(d_rdata), 32'd0);
        check({tag, "_m_en"},    32'(m_en),    32'd0);
        check({tag, "_m_wr"},    32'(m_wr),    32'd0);
        check({tag, "_m_addr"},  32'(m_addr),  32'd0);
        check({tag, "_m_wdata"}, 32'(m_wdata), 32'd0);
    endtask

    initial begin
        // Reset with live requests and stale memory data present.
        rst = 1'b1; d_en = 1'b1; d_addr = 16'h1111; i_en = 1'b1; i_addr = 16'h2222;
        forceVld = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chkQuiet("rst");
        end
        nextCycle();
        rst = 1'b0; d_en = 1'b0; i_en = 1'b0;
        @(negedge clk);
        check("post_rst_i_valid", 32'(i_valid), 32'd0);
        check("post_rst_d_valid", 32'(d_valid), 32'd0);
        check("post_rst_state", 32'(dut.state), 32'(IDLE));
        nextCycle();
        forceVld = 1'b0;
        idle(2);

        // D fill alone.
        for (int c = 0; c <= 12; c++) begin
            d_en = (c < 8); d_wr = 1'b0;
            d_addr = 16'h1230 + 16'(2 * c);
            @(negedge clk);
            check("d2_ready", 32'(d_ready), 32'(c < 8));
            check("d2_valid", 32'(d_valid), 32'(c >= 4 && c < 12));
            if (c < 8) check("d2_m_addr", 32'(m_addr), 32'(16'h1230 + 16'(2 * c)));
            if (c == 8) check("d2_state", 32'(dut.state), 32'(IDLE));
            nextCycle();
        end

        // I and D read together straight out of reset: D wins, I follows.
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            d_en = (c < 8);  d_addr = 16'h3000 + 16'(c);
            i_en = (c < 16); i_addr = 16'h2000 + 16'((c < 8) ? 0 : c - 8);
            @(negedge clk);
            check("t3_d_ready", 32'(d_ready), 32'(c < 8));
            check("t3_i_ready", 32'(i_ready), 32'(c >= 8 && c < 16));
            if (c == 16) check("t3_state", 32'(dut.state), 32'(IDLE));
            nextCycle();
        end
        idle(6);

        // D write held during an I burst, issued once the burst ends.
        d_wdata = 16'hBEEF;
        for (int c = 0; c <= 9; c++) begin
            i_en = (c < 8); i_addr = 16'h4000 + 16'(c);
            d_en = (c >= 2 && c < 9); d_wr = 1'b1; d_addr = 16'h0040;
            @(negedge clk);
            check("t4_i_ready", 32'(i_ready), 32'(c < 8));
            check("t4_d_ready", 32'(d_ready), 32'(c == 8));
            check("t4_m_wr", 32'(m_wr), 32'(c == 8));
            if (c == 8) begin
                check("t4_m_addr", 32'(m_addr), 32'h0040);
                check("t4_m_wdata", 32'(m_wdata), 32'hBEEF);
                check("t4_m_en", 32'(m_en), 32'd1);
            end
            if (c == 9) begin
                check("t4_m_en_after", 32'(m_en), 32'd0);
                check("t4_state", 32'(dut.state), 32'(IDLE));
            end
            nextCycle();
        end
        d_wr = 1'b0; d_wdata = '0;
        idle(6);

        // I fill with a two-cycle owner gap.
        begin
            int beat;
            beat = 0;
            for (int c = 0; c <= 10; c++) begin
                i_en = (c != 3 && c != 4 && c < 10);
                i_addr = 16'h6000 + 16'(beat);
                @(negedge clk);
                check("t5_i_ready", 32'(i_ready), 32'(i_en));
                if (c == 3 || c == 4) begin
                    check("t5_beat_hold", 32'(dut.beatCnt), 32'd3);
                    check("t5_state_gap", 32'(dut.state), 32'(I_BURST));
                end
                if (c == 9)  check("t5_state_last", 32'(dut.state), 32'(I_BURST));
                if (c == 10) check("t5_state_end", 32'(dut.state), 32'(IDLE));
                if (i_en) beat++;
                nextCycle();
            end
        end
        idle(6);

        // Reset after beat 5 of a D fill: in-flight words must be dropped.
        for (int c = 0; c <= 12; c++) begin
            d_en = (c < 5); d_addr = 16'h5000 + 16'(c);
            rst = (c == 5);
            @(negedge clk);
            check("t6_d_ready", 32'(d_ready), 32'(c < 5));
            check("t6_d_valid", 32'(d_valid), 32'(c == 4));
            check("t6_i_valid", 32'(i_valid), 32'd0);
            if (c == 6) check("t6_state", 32'(dut.state), 32'(IDLE));
            nextCycle();
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        check("rsp_count", 32'(nRsp), 32'd41);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
